// File: rtl/config_pkg.sv
// Shared core configuration for the PMA region logic.
// Contents:
//   cva6_cfg_t      - static configuration: rule counts plus base/length arrays
//                     for the non-idempotent, execute and cached region classes
//   cva6_cfg_empty  - all-zero configuration (no rules enabled)
//   pma_class_e     - region class encoding used by the CSR writer
//   range_check     - inclusive-base / exclusive-end region test, overflow safe
//   cfg_rule_*      - reset value of one (class, slot) table entry
package config_pkg;

  localparam int unsigned NrMaxRules = 16;
  localparam int unsigned RuleIdxW   = $clog2(NrMaxRules);

  typedef struct packed {
    int unsigned                  NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentLength;
    int unsigned                  NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionLength;
    int unsigned                  NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]  CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef enum logic [1:0] {
    PMA_NONIDEM = 2'd0,
    PMA_EXEC    = 2'd1,
    PMA_CACHED  = 2'd2
  } pma_class_e;

  // The end address is formed with 65 bits so a region reaching the top of
  // the address space never wraps; len = 0 can never match.
  function automatic logic range_check(input logic [63:0] base,
                                       input logic [63:0] len,
                                       input logic [63:0] addr);
    return (addr >= base) && ({1'b0, addr} < ({1'b0, base} + {1'b0, len}));
  endfunction

  function automatic logic cfg_rule_en(input cva6_cfg_t cfg, input pma_class_e cls,
                                       input logic [RuleIdxW-1:0] k);
    case (cls)
      PMA_NONIDEM: return 32'(k) < cfg.NrNonIdempotentRules;
      PMA_EXEC:    return 32'(k) < cfg.NrExecuteRegionRules;
      PMA_CACHED:  return 32'(k) < cfg.NrCachedRegionRules;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] cfg_rule_base(input cva6_cfg_t cfg, input pma_class_e cls,
                                                input logic [RuleIdxW-1:0] k);
    case (cls)
      PMA_NONIDEM: return cfg.NonIdempotentAddrBase[k];
      PMA_EXEC:    return cfg.ExecuteRegionAddrBase[k];
      PMA_CACHED:  return cfg.CachedRegionAddrBase[k];
      default:     return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] cfg_rule_len(input cva6_cfg_t cfg, input pma_class_e cls,
                                               input logic [RuleIdxW-1:0] k);
    case (cls)
      PMA_NONIDEM: return cfg.NonIdempotentLength[k];
      PMA_EXEC:    return cfg.ExecuteRegionLength[k];
      PMA_CACHED:  return cfg.CachedRegionLength[k];
      default:     return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/pma_region_table_match.sv
// Combinational match of one PMA rule slot against an address.
// Ports:
//   en   - slot enable
//   base - region base address
//   len  - region length in bytes
//   addr - address under test
//   hit  - slot is enabled and addr lies in [base, base+len)
module pma_rule_match
  import config_pkg::*;
(
  input  logic        en,
  input  logic [63:0] base,
  input  logic [63:0] len,
  input  logic [63:0] addr,
  output logic        hit
);

  assign hit = en && range_check(base, len, addr);

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table (non-idempotent / execute / cached).
// The table resets to the static configuration and can be rewritten one slot
// at a time by the CSR side. Lookups scan one slot index per cycle across all
// three classes in parallel and return the OR of all matches.
// Ports:
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   wr_valid_i / wr_ready_o       - rule write handshake (accepted only in IDLE)
//   wr_class_i, wr_idx_i          - target class and slot
//   wr_en_i, wr_base_i, wr_len_i  - new rule contents
//   wr_err_o                      - one-cycle pulse after a rejected write
//   lu_valid_i / lu_ready_o       - lookup request handshake
//   lu_addr_i                     - physical address to classify
//   lu_rsp_valid_o / lu_rsp_ready_i - lookup response handshake
//   lu_nonidem_o, lu_exec_o, lu_cached_o - region flags, held while valid
module pma_region_table
  import config_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned NrRules = NrMaxRules
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [1:0]                 wr_class_i,
  input  logic [$clog2(NrRules)-1:0] wr_idx_i,
  input  logic                       wr_en_i,
  input  logic [63:0]                wr_base_i,
  input  logic [63:0]                wr_len_i,
  output logic                       wr_err_o,
  input  logic                       lu_valid_i,
  output logic                       lu_ready_o,
  input  logic [63:0]                lu_addr_i,
  output logic                       lu_rsp_valid_o,
  input  logic                       lu_rsp_ready_i,
  output logic                       lu_nonidem_o,
  output logic                       lu_exec_o,
  output logic                       lu_cached_o
);

  localparam int unsigned        IdxW     = $clog2(NrRules);
  localparam logic [IdxW:0]      NrRulesW = (IdxW+1)'(NrRules);
  localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NrRules - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   cnt_q;
  logic [63:0]       addr_q;
  logic [2:0]        acc_q;
  logic              any_exec_en_q;
  logic              wr_ready_q;
  logic              lu_ready_q;
  logic              rsp_valid_q;
  logic              wr_err_q;
  logic              nonidem_q;
  logic              exec_q;
  logic              cached_q;

  logic [NrRules-1:0] en_q   [3];
  logic [63:0]        base_q [3][NrRules];
  logic [63:0]        len_q  [3][NrRules];

  logic       wr_fire;
  logic       wr_legal;
  logic [2:0] hit;

  assign wr_fire  = wr_valid_i && wr_ready_q;
  assign wr_legal = (wr_class_i != 2'd3) && ({1'b0, wr_idx_i} < NrRulesW);

  // Rule storage: reloads the static configuration on every reset, so a
  // mid-operation reset also discards all CSR reprogramming.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < int'(NrRules); k++) begin
          en_q[2'(c)][IdxW'(k)]   <= cfg_rule_en(CVA6Cfg, pma_class_e'(c), RuleIdxW'(k));
          base_q[2'(c)][IdxW'(k)] <= cfg_rule_base(CVA6Cfg, pma_class_e'(c), RuleIdxW'(k));
          len_q[2'(c)][IdxW'(k)]  <= cfg_rule_len(CVA6Cfg, pma_class_e'(c), RuleIdxW'(k));
        end
      end
    end else if (wr_fire && wr_legal) begin
      en_q[wr_class_i][wr_idx_i]   <= wr_en_i;
      base_q[wr_class_i][wr_idx_i] <= wr_base_i;
      len_q[wr_class_i][wr_idx_i]  <= wr_len_i;
    end
  end

  // One matcher per class, all looking at the slot currently being scanned.
  for (genvar c = 0; c < 3; c++) begin : g_match
    pma_rule_match u_match (
      .en   (en_q[c][cnt_q]),
      .base (base_q[c][cnt_q]),
      .len  (len_q[c][cnt_q]),
      .addr (addr_q),
      .hit  (hit[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      acc_q         <= '0;
      any_exec_en_q <= 1'b0;
      wr_ready_q    <= 1'b1;
      lu_ready_q    <= 1'b1;
      rsp_valid_q   <= 1'b0;
      wr_err_q      <= 1'b0;
      nonidem_q     <= 1'b0;
      exec_q        <= 1'b0;
      cached_q      <= 1'b0;
    end else begin
      wr_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_valid_i) wr_err_q <= !wr_legal;
          if (lu_valid_i) begin
            addr_q        <= lu_addr_i;
            acc_q         <= '0;
            any_exec_en_q <= 1'b0;
            cnt_q         <= '0;
            wr_ready_q    <= 1'b0;
            lu_ready_q    <= 1'b0;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          acc_q         <= acc_q | hit;
          any_exec_en_q <= any_exec_en_q | en_q[PMA_EXEC][cnt_q];
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            // Fold in the last slot directly so the flags are final when
            // the response goes valid. No enabled execute rule means the
            // whole address space is executable.
            nonidem_q   <= acc_q[PMA_NONIDEM] | hit[PMA_NONIDEM];
            cached_q    <= acc_q[PMA_CACHED] | hit[PMA_CACHED];
            exec_q      <= acc_q[PMA_EXEC] | hit[PMA_EXEC]
                         | ~(any_exec_en_q | en_q[PMA_EXEC][cnt_q]);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (lu_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            wr_ready_q  <= 1'b1;
            lu_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready_o     = wr_ready_q;
  assign lu_ready_o     = lu_ready_q;
  assign lu_rsp_valid_o = rsp_valid_q;
  assign wr_err_o       = wr_err_q;
  assign lu_nonidem_o   = nonidem_q;
  assign lu_exec_o      = exec_q;
  assign lu_cached_o    = cached_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Self-checking bench for pma_region_table: directed steps followed by
// random write/lookup traffic, compared against an array-based region model.
module tb_pma_region_table;
  import config_pkg::*;

  localparam int unsigned NR = 6;
  localparam int unsigned IW = $clog2(NR);

  // One cached rule; the non-idempotent slot 0 holds a catch-all region but
  // its rule count is zero, so it must come out of reset disabled.
  function automatic cva6_cfg_t make_cfg();
    cva6_cfg_t c;
    c = '0;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h0000_0000_8000_0000;
    c.CachedRegionLength[0]    = 64'h0000_0000_4000_0000;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
    return c;
  endfunction

  localparam cva6_cfg_t TbCfg = make_cfg();

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_class = '0;
  logic [IW-1:0] wr_idx = '0;
  logic          wr_en = 1'b0;
  logic [63:0]   wr_base = '0;
  logic [63:0]   wr_len = '0;
  logic          wr_err;
  logic          lu_valid = 1'b0;
  logic          lu_ready;
  logic [63:0]   lu_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          f_nonidem, f_exec, f_cached;

  int checks = 0;
  int errors = 0;

  pma_region_table #(.CVA6Cfg(TbCfg), .NrRules(NR)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_class_i     (wr_class),
    .wr_idx_i       (wr_idx),
    .wr_en_i        (wr_en),
    .wr_base_i      (wr_base),
    .wr_len_i       (wr_len),
    .wr_err_o       (wr_err),
    .lu_valid_i     (lu_valid),
    .lu_ready_o     (lu_ready),
    .lu_addr_i      (lu_addr),
    .lu_rsp_valid_o (rsp_valid),
    .lu_rsp_ready_i (rsp_ready),
    .lu_nonidem_o   (f_nonidem),
    .lu_exec_o      (f_exec),
    .lu_cached_o    (f_cached)
  );

  always #5 clk = ~clk;

  // Reference table: index 0 non-idempotent, 1 execute, 2 cached.
  bit          m_en   [3][NR];
  logic [63:0] m_base [3][NR];
  logic [63:0] m_len  [3][NR];

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < int'(NR); k++) begin
        m_en[c][k] = 1'b0; m_base[c][k] = '0; m_len[c][k] = '0;
      end
    m_en[2][0]   = 1'b1;
    m_base[2][0] = 64'h8000_0000;
    m_len[2][0]  = 64'h4000_0000;
  endtask

  // Returns {cached, exec, nonidem}.
  function automatic logic [2:0] model_lookup(input logic [63:0] a);
    logic [2:0] r;
    bit any_x;
    r = '0;
    any_x = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < int'(NR); k++)
        if (m_en[c][k]) begin
          if (c == 1) any_x = 1'b1;
          if (a >= m_base[c][k] && (a - m_base[c][k]) < m_len[c][k]) r[c] = 1'b1;
        end
    if (!any_x) r[1] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/wr_ready"}, wr_ready, 1);
    check({tag, "/lu_ready"}, lu_ready, 1);
    check({tag, "/rsp_valid"}, rsp_valid, 0);
    check({tag, "/wr_err"}, wr_err, 0);
    check({tag, "/flags"}, {f_cached, f_exec, f_nonidem}, 0);
  endtask

  // One IDLE-side transaction: optional write, optional lookup in the same
  // cycle, then (for a lookup) latency, flag, backpressure and release checks.
  task automatic txn(input string tag, input bit do_wr, input logic [1:0] cls,
                     input logic [IW-1:0] idx, input bit en, input logic [63:0] base,
                     input logic [63:0] len, input bit do_lu, input logic [63:0] addr,
                     input int hold);
    int n;
    logic [2:0] exp;
    bit legal;
    @(negedge clk);
    wr_valid = do_wr; wr_class = cls; wr_idx = idx; wr_en = en;
    wr_base = base; wr_len = len;
    lu_valid = do_lu; lu_addr = addr;
    n = 0;
    while (!(wr_ready && lu_ready) && n < 200) begin @(negedge clk); n++; end
    check({tag, "/idle_reached"}, 64'(n < 200), 1);
    @(posedge clk);
    legal = (cls != 2'd3) && (int'(idx) < int'(NR));
    if (do_wr && legal) begin
      m_en[cls][idx] = en; m_base[cls][idx] = base; m_len[cls][idx] = len;
    end
    exp = model_lookup(addr);
    @(negedge clk);
    wr_valid = 1'b0; lu_valid = 1'b0;
    n = 0;
    if (do_wr) check({tag, "/wr_err"}, wr_err, 64'(!legal));
    if (do_lu) begin
      check({tag, "/busy_lu_ready"}, lu_ready, 0);
      check({tag, "/busy_wr_ready"}, wr_ready, 0);
    end
    if (do_wr) begin
      @(negedge clk); n++;
      check({tag, "/wr_err_pulse"}, wr_err, 0);
    end
    if (do_lu) begin
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      check({tag, "/latency"}, n, NR);
      check({tag, "/nonidem"}, f_nonidem, exp[0]);
      check({tag, "/exec"}, f_exec, exp[1]);
      check({tag, "/cached"}, f_cached, exp[2]);
      lu_valid = (hold > 0); lu_addr = ~addr;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "/hold_valid"}, rsp_valid, 1);
        check({tag, "/hold_lu_ready"}, lu_ready, 0);
        check({tag, "/hold_flags"}, {f_cached, f_exec, f_nonidem}, exp);
      end
      rsp_ready = 1'b1; lu_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "/released"}, {rsp_valid, lu_ready}, 2'b01);
    end
  endtask

  task automatic lookup(input string tag, input logic [63:0] addr);
    txn(tag, 1'b0, 2'd0, '0, 1'b0, '0, '0, 1'b1, addr, 0);
  endtask

  task automatic write(input string tag, input logic [1:0] cls, input logic [IW-1:0] idx,
                       input bit en, input logic [63:0] base, input logic [63:0] len);
    txn(tag, 1'b1, cls, idx, en, base, len, 1'b0, '0, 0);
  endtask

  initial begin
    int n;
    logic [2:0] exp;
    logic [63:0] anchors [4];
    logic [63:0] a, b, l;
    bit dw, dl;

    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents and region boundaries.
    lookup("default", 64'h8000_1000);
    lookup("top_in", 64'hBFFF_FFFF);
    lookup("top_out", 64'hC000_0000);
    lookup("below_base", 64'h7FFF_FFFF);
    lookup("disabled_cfg_slot", 64'h10);

    // Region touching the top of the address space, then a zero length.
    write("wr_top", 2'd2, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000);
    lookup("overflow_in", 64'hFFFF_FFFF_FFFF_FFF8);
    write("wr_len0", 2'd2, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h0);
    lookup("len0", 64'hFFFF_FFFF_FFFF_FFF8);
    lookup("len0_base", 64'hFFFF_FFFF_FFFF_F000);

    // Same-cycle write and lookup: the scan sees the new execute rule.
    txn("collide", 1'b1, 2'd1, 3'd0, 1'b1, 64'h1000, 64'h1000, 1'b1, 64'h3000, 0);
    lookup("exec_in", 64'h1800);

    // Rejected writes leave the table untouched.
    write("bad_class", 2'd3, 3'd1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    write("bad_idx6", 2'd2, 3'd6, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    write("bad_idx7", 2'd0, 3'd7, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    lookup("after_bad", 64'h10);

    // Response backpressure with a competing lookup request.
    txn("backpressure", 1'b0, 2'd0, '0, 1'b0, '0, '0, 1'b1, 64'h8000_0000, 10);

    // Write presented during a scan waits until the response is consumed.
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = 64'h1_0000_0040;
    @(posedge clk);
    exp = model_lookup(64'h1_0000_0040);
    @(negedge clk);
    lu_valid = 1'b0;
    wr_valid = 1'b1; wr_class = 2'd0; wr_idx = 3'd2; wr_en = 1'b1;
    wr_base = 64'h1_0000_0000; wr_len = 64'h100;
    n = 0;
    while (!rsp_valid && n < 100) begin
      check("blocked_scan_wr_ready", wr_ready, 0);
      @(negedge clk); n++;
    end
    check("blocked_resp_valid", rsp_valid, 1);
    check("blocked_resp_wr_ready", wr_ready, 0);
    check("blocked_flags", {f_cached, f_exec, f_nonidem}, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("blocked_then_ready", wr_ready, 1);
    @(posedge clk);
    m_en[0][2] = 1'b1; m_base[0][2] = 64'h1_0000_0000; m_len[0][2] = 64'h100;
    @(negedge clk);
    wr_valid = 1'b0;
    check("blocked_wr_err", wr_err, 0);
    lookup("blocked_applied", 64'h1_0000_0040);

    // Random traffic against the model.
    anchors[0] = 64'h1000;
    anchors[1] = 64'h8000_0000;
    anchors[2] = 64'hFFFF_FFFF_FFFF_F000;
    anchors[3] = 64'h4_0000_0000;
    for (int i = 0; i < 40; i++) begin
      b = anchors[$urandom_range(0, 3)] + 64'($urandom_range(0, 255) * 16);
      case ($urandom_range(0, 3))
        0: l = 64'h0;
        1: l = 64'hFFFF_FFFF_FFFF_FFFF;
        default: l = 64'($urandom_range(1, 4096));
      endcase
      a = anchors[$urandom_range(0, 3)] + 64'($urandom_range(0, 8192));
      if ($urandom_range(0, 4) == 0) a = b - 64'd1;
      dw = ($urandom_range(0, 1) == 1);
      dl = !dw || ($urandom_range(0, 2) == 0);
      txn($sformatf("rand%0d", i), dw, 2'($urandom_range(0, 3)), IW'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0), b, l, dl, a, 0);
    end

    // Make sure an execute rule is installed, then reset in the middle of a scan.
    write("pre_reset_wr", 2'd1, 3'd0, 1'b1, 64'h1000, 64'h1000);
    lookup("pre_reset_lu", 64'h3000);
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = 64'h8000_1000;
    @(posedge clk);
    @(negedge clk);
    lu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_scan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lookup("restored_exec", 64'h3000);
    lookup("restored_cached", 64'h8000_1000);
    lookup("restored_top", 64'hFFFF_FFFF_FFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
